pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_if.sv | 27 ++
 rtl/pipe_stage_skid.sv | 102 ++++++++++
 tb/tb_pipe_stage_skid.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between IF, the skid stage and ID.
// The slave modport is the stage's view; the master modport is the driver/monitor view.
interface pipe_stage_skid_if #(
    parameter int N  = 32,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  pc_in;
    logic [N-1:0]  instr_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  pc_out;
    logic [N-1:0]  instr_out;
    logic [CW-1:0] stall_cnt;

    modport slave (
        input  in_valid, pc_in, instr_in, flush, out_ready,
        output in_ready, out_valid, pc_out, instr_out, stall_cnt
    );

    modport master (
        output in_valid, pc_in, instr_in, flush, out_ready,
        input  in_ready, out_valid, pc_out, instr_out, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// IF/ID pipeline stage with a main register and a one-entry skid buffer.
// in_ready is registered, so upstream never sees a combinational path from out_ready.
module pipe_stage_skid #(
    parameter int             N    = 32,
    parameter logic [N-1:0]   INIT = '0,
    parameter logic [N-1:0]   NOP  = N'(32'h0000_0013),
    parameter int             CW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stage_skid_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  main_pc_q, main_pc_d, main_ins_q, main_ins_d;
    logic [N-1:0]  skid_pc_q, skid_pc_d, skid_ins_q, skid_ins_d;
    logic          in_ready_q;
    logic [CW-1:0] stall_q, stall_d;
    logic          out_valid;
    logic          in_xfer, out_xfer;

    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = bus.in_valid & in_ready_q;
    assign out_xfer  = out_valid & bus.out_ready;

    always_comb begin
        state_d    = state_q;
        main_pc_d  = main_pc_q;
        main_ins_d = main_ins_q;
        skid_pc_d  = skid_pc_q;
        skid_ins_d = skid_ins_q;
        stall_d    = stall_q;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d    = ONE;
                    main_pc_d  = bus.pc_in;
                    main_ins_d = bus.instr_in;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_pc_d  = bus.pc_in;
                    main_ins_d = bus.instr_in;
                end else if (in_xfer) begin
                    state_d    = TWO;
                    skid_pc_d  = bus.pc_in;
                    skid_ins_d = bus.instr_in;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d    = ONE;
                    main_pc_d  = skid_pc_q;
                    main_ins_d = skid_ins_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (bus.flush) state_d = EMPTY;

        // An empty stage always presents the idle values, whether drained or flushed.
        if (state_d == EMPTY) begin
            main_pc_d  = INIT;
            main_ins_d = NOP;
        end

        if (bus.in_valid && !in_ready_q && (stall_q != '1))
            stall_d = stall_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_pc_q  <= INIT;
            main_ins_q <= NOP;
            skid_pc_q  <= '0;
            skid_ins_q <= '0;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_pc_q  <= main_pc_d;
            main_ins_q <= main_ins_d;
            skid_pc_q  <= skid_pc_d;
            skid_ins_q <= skid_ins_d;
            in_ready_q <= (state_d != TWO);
            stall_q    <= stall_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.pc_out    = main_pc_q;
    assign bus.instr_out = main_ins_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed vector table plus saturation and randomized queue-model sequences for pipe_stage_skid.
module tb_pipe_stage_skid;
    localparam int          N       = 32;
    localparam int          CW      = 4;
    localparam logic [31:0] INIT_PC = 32'hDEAD_0000;
    localparam logic [31:0] NOP_I   = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stage_skid_if #(.N(N), .CW(CW)) bus ();

    pipe_stage_skid #(.N(N), .INIT(INIT_PC), .NOP(NOP_I), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst, iv, fl, ordy;
        logic [31:0] pc;
        logic        e_ir, e_ov;
        logic [31:0] e_pc;
        logic [3:0]  e_st;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic v(input logic rst, iv, fl, ordy, input logic [31:0] pc,
                     input logic e_ir, e_ov, input logic [31:0] e_pc, input logic [3:0] e_st);
        vec_t r;
        r.rst = rst; r.iv = iv; r.fl = fl; r.ordy = ordy; r.pc = pc;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_pc = e_pc; r.e_st = e_st;
        vt.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, iv, fl, ordy, input logic [31:0] pc);
        reset         = rst;
        bus.in_valid  = iv;
        bus.flush     = fl;
        bus.out_ready = ordy;
        bus.pc_in     = pc;
        bus.instr_in  = ins_of(pc);
    endtask

    logic [31:0] q[$];
    logic        mready;
    logic [3:0]  mstall;
    logic        r_iv, r_fl, r_or;
    logic [31:0] nextpc;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        //  rst iv fl or  pc        ir ov pc        stall
        v(1, 0, 0, 0, 32'h00,  0, 0, INIT_PC, 0);   // reset state
        v(1, 1, 0, 1, 32'h40,  0, 0, INIT_PC, 0);   // reset beats input
        v(0, 0, 0, 0, 32'h00,  1, 0, INIT_PC, 0);   // in_ready rises after reset
        v(0, 1, 0, 1, 32'h00,  1, 1, 32'h00,  0);   // streaming
        v(0, 1, 0, 1, 32'h04,  1, 1, 32'h04,  0);
        v(0, 1, 0, 1, 32'h08,  1, 1, 32'h08,  0);
        v(0, 1, 0, 1, 32'h0C,  1, 1, 32'h0C,  0);
        v(0, 0, 0, 1, 32'h00,  1, 0, INIT_PC, 0);   // drain to empty
        v(0, 1, 0, 0, 32'h10,  1, 1, 32'h10,  0);   // backpressure
        v(0, 1, 0, 0, 32'h14,  0, 1, 32'h10,  0);
        v(0, 0, 0, 0, 32'h00,  0, 1, 32'h10,  0);
        v(0, 1, 0, 0, 32'h18,  0, 1, 32'h10,  1);   // rejected, counted stall
        v(0, 0, 0, 1, 32'h00,  1, 1, 32'h14,  1);
        v(0, 0, 0, 1, 32'h00,  1, 0, INIT_PC, 1);
        v(0, 1, 0, 0, 32'h20,  1, 1, 32'h20,  1);   // flush from TWO
        v(0, 1, 0, 0, 32'h24,  0, 1, 32'h20,  1);
        v(0, 1, 1, 0, 32'h28,  1, 0, INIT_PC, 2);
        v(0, 0, 0, 1, 32'h00,  1, 0, INIT_PC, 2);
        v(0, 1, 0, 0, 32'h30,  1, 1, 32'h30,  2);   // flush beats in+out transfer
        v(0, 1, 1, 1, 32'h34,  1, 0, INIT_PC, 2);
        v(0, 0, 0, 1, 32'h00,  1, 0, INIT_PC, 2);
        v(0, 1, 0, 0, 32'h40,  1, 1, 32'h40,  2);   // reset mid-operation
        v(1, 1, 0, 1, 32'h44,  0, 0, INIT_PC, 0);
        v(0, 0, 0, 0, 32'h00,  1, 0, INIT_PC, 0);
        v(1, 1, 1, 1, 32'h48,  0, 0, INIT_PC, 0);   // reset over flush
        v(0, 0, 0, 0, 32'h00,  1, 0, INIT_PC, 0);

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].iv, vt[i].fl, vt[i].ordy, vt[i].pc);
            @(posedge clk); #1;
            chk($sformatf("vec%0d in_ready", i),  {31'b0, bus.in_ready},  {31'b0, vt[i].e_ir});
            chk($sformatf("vec%0d out_valid", i), {31'b0, bus.out_valid}, {31'b0, vt[i].e_ov});
            chk($sformatf("vec%0d pc_out", i),    bus.pc_out,    vt[i].e_pc);
            chk($sformatf("vec%0d instr_out", i), bus.instr_out, vt[i].e_ov ? ins_of(vt[i].e_pc) : NOP_I);
            chk($sformatf("vec%0d stall_cnt", i), {28'b0, bus.stall_cnt}, {28'b0, vt[i].e_st});
        end

        // Saturation: park in TWO with in_valid held high.
        drive(0, 1, 0, 0, 32'h50); @(posedge clk); #1;
        drive(0, 1, 0, 0, 32'h54); @(posedge clk); #1;
        chk("sat in_ready", {31'b0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 0, 32'h58);
            @(posedge clk); #1;
            chk($sformatf("sat stall%0d", i), {28'b0, bus.stall_cnt}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            chk($sformatf("sat pc%0d", i), bus.pc_out, 32'h50);
        end
        drive(0, 1, 1, 0, 32'h5C); @(posedge clk); #1;
        chk("sat flush keeps stall", {28'b0, bus.stall_cnt}, 32'd15);
        chk("sat flush empties", {31'b0, bus.out_valid}, 32'd0);
        drive(1, 0, 0, 0, 32'h0); @(posedge clk); #1;
        chk("sat reset clears stall", {28'b0, bus.stall_cnt}, 32'd0);
        drive(0, 0, 0, 0, 32'h0); @(posedge clk); #1;

        // Randomized traffic against a reference queue.
        mready = 1'b1;
        mstall = 4'd0;
        nextpc = 32'h1000;
        for (int c = 0; c < 300; c++) begin
            r_iv = 1'($urandom_range(0, 1));
            r_fl = ($urandom_range(0, 15) == 0);
            r_or = 1'($urandom_range(0, 1));
            drive(0, r_iv, r_fl, 1'b0, nextpc);
            #1;
            chk("rnd in_ready or=0", {31'b0, bus.in_ready}, {31'b0, mready});
            bus.out_ready = 1'b1;
            #1;
            chk("rnd in_ready or=1", {31'b0, bus.in_ready}, {31'b0, mready});
            bus.out_ready = r_or;
            #1;
            chk("rnd out_valid", {31'b0, bus.out_valid}, {31'b0, (q.size() != 0)});
            chk("rnd pc_out", bus.pc_out, (q.size() != 0) ? q[0] : INIT_PC);
            chk("rnd instr_out", bus.instr_out, (q.size() != 0) ? ins_of(q[0]) : NOP_I);
            chk("rnd stall_cnt", {28'b0, bus.stall_cnt}, {28'b0, mstall});
            @(posedge clk);
            if (r_iv && !mready && mstall != 4'd15) mstall = mstall + 4'd1;
            if (r_fl) begin
                q.delete();
            end else begin
                if (r_or && q.size() != 0) void'(q.pop_front());
                if (r_iv && mready) q.push_back(nextpc);
            end
            mready = (q.size() < 2);
            nextpc = nextpc + 32'd4;
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
